// File: rtl/carrier_derotator.sv
// Carrier de-rotator: NCO-driven conjugate complex multiply that strips a carrier
// frequency/phase offset from a valid-strobed I/Q stream, saturating back to the input format.
module carrier_derotator #(
    parameter int NB_DATA     = 8,
    parameter int NBF_DATA    = 7,
    parameter int NB_COEF     = 8,
    parameter int NBF_COEF    = 7,
    parameter int NB_PHASE    = 16,
    parameter int NB_LUT_ADDR = 8
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [NB_DATA-1:0]  i_dataI,
    input  logic [NB_DATA-1:0]  i_dataQ,
    input  logic [NB_PHASE-1:0] i_freq_word,
    input  logic                i_phase_load,
    input  logic [NB_PHASE-1:0] i_phase_init,
    output logic                o_valid,
    output logic [NB_DATA-1:0]  o_dataI,
    output logic [NB_DATA-1:0]  o_dataQ,
    output logic [NB_PHASE-1:0] o_phase
);

    localparam int NB_PROD = NB_DATA + NB_COEF;
    localparam int NB_SUM  = NB_PROD + 1;

    // Quarter-wave table: round(127*sin(2*pi*k/256)) for k = 0..64.
    function automatic logic [6:0] quarter_sine(input logic [6:0] idx);
        logic [6:0] q;
        case (idx)
            7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
            7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
            7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
            7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
            7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
            7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
            7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
            7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
            7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
            7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
            7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
            7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
            7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
            7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
            7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
            7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
            default: q = 7'd127;
        endcase
        return q;
    endfunction

    // Full-circle sine from quadrant symmetry; cosine is the same lookup a quarter turn ahead.
    function automatic logic signed [NB_COEF-1:0] sine_lut(input logic [NB_LUT_ADDR-1:0] addr);
        logic [6:0]                idx;
        logic signed [NB_COEF-1:0] mag;
        idx = addr[6] ? (7'd64 - {1'b0, addr[5:0]}) : {1'b0, addr[5:0]};
        mag = {{(NB_COEF-7){1'b0}}, quarter_sine(idx)};
        return addr[7] ? -mag : mag;
    endfunction

    function automatic logic signed [NB_DATA-1:0] sat_trunc(input logic signed [NB_SUM-1:0] s);
        logic [NB_SUM-NB_DATA-NBF_COEF:0] top;
        top = s[NB_SUM-1 : NB_DATA+NBF_COEF-1];
        if ((&top) || !(|top))
            return s[NB_DATA+NBF_COEF-1 -: NB_DATA];
        else if (s[NB_SUM-1])
            return {1'b1, {(NB_DATA-1){1'b0}}};
        else
            return {1'b0, {(NB_DATA-1){1'b1}}};
    endfunction

    logic [NB_PHASE-1:0]    acc;
    logic [NB_PHASE-1:0]    phase_sel;
    logic [NB_LUT_ADDR-1:0] lut_addr;

    logic signed [NB_DATA-1:0] data_i_p1, data_q_p1;
    logic signed [NB_COEF-1:0] cos_p1, sin_p1;
    logic [NB_PHASE-1:0]       phase_p1;
    logic                      vld_p1;

    logic signed [NB_PROD-1:0] prod_ic_p2, prod_qs_p2, prod_qc_p2, prod_is_p2;
    logic [NB_PHASE-1:0]       phase_p2;
    logic                      vld_p2;

    logic signed [NB_SUM-1:0]  sum_i, sum_q;

    assign phase_sel = i_phase_load ? i_phase_init : acc;
    assign lut_addr  = phase_sel[NB_PHASE-1 -: NB_LUT_ADDR];

    always_comb begin
        sum_i = $signed({prod_ic_p2[NB_PROD-1], prod_ic_p2}) + $signed({prod_qs_p2[NB_PROD-1], prod_qs_p2});
        sum_q = $signed({prod_qc_p2[NB_PROD-1], prod_qc_p2}) - $signed({prod_is_p2[NB_PROD-1], prod_is_p2});
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            acc        <= '0;
            data_i_p1  <= '0;
            data_q_p1  <= '0;
            cos_p1     <= '0;
            sin_p1     <= '0;
            phase_p1   <= '0;
            vld_p1     <= 1'b0;
            prod_ic_p2 <= '0;
            prod_qs_p2 <= '0;
            prod_qc_p2 <= '0;
            prod_is_p2 <= '0;
            phase_p2   <= '0;
            vld_p2     <= 1'b0;
            o_dataI    <= '0;
            o_dataQ    <= '0;
            o_phase    <= '0;
            o_valid    <= 1'b0;
        end else begin
            if (i_valid)
                acc <= phase_sel + i_freq_word;
            else if (i_phase_load)
                acc <= i_phase_init;

            // Stage 1: capture sample, phasor and the phase it was taken at
            data_i_p1 <= $signed(i_dataI);
            data_q_p1 <= $signed(i_dataQ);
            cos_p1    <= sine_lut(lut_addr + NB_LUT_ADDR'(64));
            sin_p1    <= sine_lut(lut_addr);
            phase_p1  <= phase_sel;
            vld_p1    <= i_valid;

            // Stage 2: full-precision products
            prod_ic_p2 <= NB_PROD'(data_i_p1) * NB_PROD'(cos_p1);
            prod_qs_p2 <= NB_PROD'(data_q_p1) * NB_PROD'(sin_p1);
            prod_qc_p2 <= NB_PROD'(data_q_p1) * NB_PROD'(cos_p1);
            prod_is_p2 <= NB_PROD'(data_i_p1) * NB_PROD'(sin_p1);
            phase_p2   <= phase_p1;
            vld_p2     <= vld_p1;

            // Stage 3: conjugate sums, truncated and saturated to the I/Q format
            o_dataI <= sat_trunc(sum_i);
            o_dataQ <= sat_trunc(sum_q);
            o_phase <= phase_p2;
            o_valid <= vld_p2;
        end
    end

endmodule

// File: tb/tb_carrier_derotator.sv
// Bench for carrier_derotator: directed test-plan steps followed by randomized traffic,
// checked against a real-arithmetic NCO/derotation model with a three-cycle delay line.
module tb_carrier_derotator;

    localparam real PI = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vld = 1'b0;
    logic [7:0]  di = '0, dq = '0;
    logic [15:0] freq = '0;
    logic        load = 1'b0;
    logic [15:0] init = '0;
    logic        o_valid;
    logic [7:0]  o_dataI, o_dataQ;
    logic [15:0] o_phase;

    int nchecks = 0;
    int nerrors = 0;

    typedef struct {
        bit vld;
        bit chk;
        int i;
        int q;
        int ph;
    } ent_t;

    ent_t hist[3];
    int   acc_m = 0;

    carrier_derotator dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_valid     (vld),
        .i_dataI     (di),
        .i_dataQ     (dq),
        .i_freq_word (freq),
        .i_phase_load(load),
        .i_phase_init(init),
        .o_valid     (o_valid),
        .o_dataI     (o_dataI),
        .o_dataQ     (o_dataQ),
        .o_phase     (o_phase)
    );

    always #5 clk = ~clk;

    function automatic int clamp8(int x);
        if (x > 127) return 127;
        if (x < -128) return -128;
        return x;
    endfunction

    function automatic int round_coef(real x);
        return clamp8($rtoi($floor(127.0 * x + 0.5)));
    endfunction

    // Ideal derotation: multiply by conj(e^{j*theta}), rescale by 2^-7 with floor, clip to 8 bits.
    function automatic void model(input int i_in, input int q_in, input int ph,
                                  output int i_out, output int q_out);
        int  k, c, s;
        real theta;
        k     = (ph >> 8) & 255;
        theta = 2.0 * PI * real'(k) / 256.0;
        c     = round_coef($cos(theta));
        s     = round_coef($sin(theta));
        i_out = clamp8($rtoi($floor(real'(i_in * c + q_in * s) / 128.0)));
        q_out = clamp8($rtoi($floor(real'(q_in * c - i_in * s) / 128.0)));
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nerrors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        ent_t e;
        int   p, ei, eq;
        @(posedge clk);
        if (rst) begin
            acc_m = 0;
            e = '{vld: 1'b0, chk: 1'b1, i: 0, q: 0, ph: 0};
            hist[0] = e;
            hist[1] = e;
            hist[2] = e;
        end else begin
            p = load ? int'(init) : acc_m;
            model($signed(di), $signed(dq), p, ei, eq);
            e = '{vld: vld, chk: vld, i: ei, q: eq, ph: p};
            if (vld)
                acc_m = (p + int'(freq)) % 65536;
            else if (load)
                acc_m = int'(init);
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = e;
        end
        #1;
        chk("model_valid", o_valid, hist[2].vld);
        if (hist[2].chk) begin
            chk("model_dataI", $signed(o_dataI), hist[2].i);
            chk("model_dataQ", $signed(o_dataQ), hist[2].q);
            chk("model_phase", o_phase, hist[2].ph);
        end
    endtask

    task automatic send(input bit v, input int i_in, input int q_in, input bit ld,
                        input int ini, input int fr, input bit r);
        vld  = v;
        di   = 8'(i_in);
        dq   = 8'(q_in);
        load = ld;
        init = 16'(ini);
        freq = 16'(fr);
        rst  = r;
        tick();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) send(0, 0, 0, 0, 0, int'(freq), 0);
    endtask

    initial begin
        int ri, rq;
        bit rv, rl, rr;

        // reset state
        send(0, 0, 0, 0, 0, 0, 1);
        send(0, 0, 0, 0, 0, 0, 1);
        chk("reset_valid", o_valid, 0);
        chk("reset_dataI", $signed(o_dataI), 0);
        chk("reset_dataQ", $signed(o_dataQ), 0);
        chk("reset_phase", o_phase, 0);

        // zero phase
        send(1, 64, -32, 1, 'h0000, 0, 0);
        idle(2);
        chk("zero_valid", o_valid, 1);
        chk("zero_dataI", $signed(o_dataI), 63);
        chk("zero_dataQ", $signed(o_dataQ), -32);
        chk("zero_phase", o_phase, 'h0000);

        // quarter turn
        send(1, 64, 0, 1, 'h4000, 0, 0);
        idle(2);
        chk("quarter_dataI", $signed(o_dataI), 0);
        chk("quarter_dataQ", $signed(o_dataQ), -64);
        chk("quarter_phase", o_phase, 'h4000);

        // negative saturation at k=32
        send(1, -128, -128, 1, 'h2000, 0, 0);
        idle(2);
        chk("sat_dataI", $signed(o_dataI), -128);
        chk("sat_dataQ", $signed(o_dataQ), 0);

        // NCO sweep through the wrap, then a 5-cycle gap
        send(1, 10, 20, 1, 'hFF00, 'h0200, 0);
        send(1, 30, -40, 0, 0, 'h0200, 0);
        send(1, -50, 60, 0, 0, 'h0200, 0);
        chk("sweep_phase0", o_phase, 'hFF00);
        send(1, 127, 127, 0, 0, 'h0200, 0);
        chk("sweep_phase1", o_phase, 'h0100);
        idle(1);
        chk("sweep_phase2", o_phase, 'h0300);
        idle(1);
        chk("sweep_phase3", o_phase, 'h0500);
        idle(3);
        send(1, 5, 5, 0, 0, 'h0200, 0);
        idle(2);
        chk("gap_valid", o_valid, 1);
        chk("gap_phase", o_phase, 'h0700);

        // load together with valid
        send(1, 100, 0, 1, 'h8000, 'h0100, 0);
        send(1, 100, 0, 0, 0, 'h0100, 0);
        idle(1);
        chk("collide_dataI", $signed(o_dataI), -100);
        chk("collide_dataQ", $signed(o_dataQ), 0);
        chk("collide_phase", o_phase, 'h8000);
        idle(1);
        chk("collide_next_phase", o_phase, 'h8100);

        // reset in the middle of continuous traffic
        for (int j = 0; j < 6; j++)
            send(1, int'($urandom_range(0, 255)) - 128, int'($urandom_range(0, 255)) - 128,
                 0, 0, 'h0345, 0);
        send(1, 50, 50, 0, 0, 'h0345, 1);
        chk("midrst_valid0", o_valid, 0);
        chk("midrst_dataI0", $signed(o_dataI), 0);
        chk("midrst_phase0", o_phase, 0);
        send(1, 40, -40, 0, 0, 'h0123, 0);
        chk("midrst_valid1", o_valid, 0);
        send(1, 20, 20, 0, 0, 'h0123, 0);
        chk("midrst_valid2", o_valid, 0);
        send(0, 0, 0, 0, 0, 'h0123, 0);
        chk("midrst_first_valid", o_valid, 1);
        chk("midrst_first_phase", o_phase, 0);

        // randomized traffic with gaps, loads, extreme data and occasional resets
        for (int n = 0; n < 600; n++) begin
            rv = ($urandom_range(0, 3) != 0);
            rl = ($urandom_range(0, 15) == 0);
            rr = ($urandom_range(0, 149) == 0);
            ri = int'($urandom_range(0, 255)) - 128;
            rq = int'($urandom_range(0, 255)) - 128;
            if ($urandom_range(0, 7) == 0) ri = ($urandom_range(0, 1) != 0) ? 127 : -128;
            if ($urandom_range(0, 7) == 0) rq = ($urandom_range(0, 1) != 0) ? 127 : -128;
            if ($urandom_range(0, 31) == 0) freq = 16'($urandom_range(0, 65535));
            send(rv, ri, rq, rl, int'($urandom_range(0, 65535)), int'(freq), rr);
        end
        idle(3);

        $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
        $finish;
    end

endmodule
